fetch_queue: RTL and testbench

- Consumer side of the fetch-address interface.
- Accepts the PC presented by the fetch stage and issues one instruction-memory request per accepted PC.
- Buffers returned {pc, instruction} pairs in a FIFO for decode.
- Drives the fetch stage's `ready`, and discards in-flight and buffered work on a branch mispredict.

---
 rtl/fetch_queue.sv | 143 ++++++++++++++
 tb/tb_fetch_queue.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: consumer side of the fetch-address interface.
// Accepts a PC from the fetch stage, issues one instruction-memory request per
// accepted PC, and buffers returned {pc, instruction} pairs in a FIFO for decode.
// A branch mispredict discards the in-flight response and all buffered entries.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   f_addr, mispred, ready   fetch-stage PC, redirect/flush, accept handshake
//   imem_req, imem_addr      single-cycle request pulse and its address
//   imem_ack, imem_rdata     response strobe and instruction
//   d_valid, d_ready         decode handshake on the FIFO head
//   d_addr, d_instr          PC and instruction of the head entry (0 when empty)
//
// Optional feature: define FETCH_QUEUE_BYPASS_EN to let a response reach decode
// in its ack cycle when the FIFO is empty and decode is ready.
module fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] f_addr,
    input  logic            mispred,
    output logic            ready,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            d_valid,
    input  logic            d_ready,
    output logic [XLEN-1:0] d_addr,
    output logic [XLEN-1:0] d_instr
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t          state;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] pend_addr;
    logic [XLEN-1:0] mem_addr  [DEPTH];
    logic [XLEN-1:0] mem_instr [DEPTH];

    logic empty;
    logic not_full;
    logic accept;
    logic ack_ok;
    logic byp;
    logic push;
    logic pop;

    assign empty    = (count == '0);
    assign not_full = (count < CW'(DEPTH));
    // Held low during reset so the fetch stage never advances while state clears.
    assign accept   = !rst && (state == IDLE) && !mispred && not_full;
    assign ack_ok   = (state == WAIT) && imem_ack && !mispred;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign byp = ack_ok && empty && d_ready;
`else
    assign byp = 1'b0;
`endif

    assign push = ack_ok && !byp;
    assign pop  = !empty && d_ready;

    // Mispredict raises ready so the fetch stage loads the redirect target.
    assign ready     = !rst && (accept || mispred);
    assign imem_req  = accept;
    assign imem_addr = f_addr;

    assign d_valid = !empty || byp;
    assign d_addr  = !empty ? mem_addr[rd_ptr]  : (byp ? pend_addr  : '0);
    assign d_instr = !empty ? mem_instr[rd_ptr] : (byp ? imem_rdata : '0);

    // Request FSM: one request in flight; DROP swallows the response of a flushed request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pend_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= WAIT;
                        pend_addr <= f_addr;
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        state <= IDLE;
                    end else if (mispred) begin
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO pointers and occupancy; flush overrides any push or pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (mispred) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents are don't-care until counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr]  <= pend_addr;
            mem_instr[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized self-checking bench for fetch_queue.
// A transaction-level model (one optional in-flight request plus a queue of
// buffered entries) predicts every output each cycle.
module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned NCYC  = 4000;

    logic            clk = 1'b0;
    logic            rst;
    logic [XLEN-1:0] f_addr;
    logic            mispred;
    logic            ready;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;
    logic            d_valid;
    logic            d_ready;
    logic [XLEN-1:0] d_addr;
    logic [XLEN-1:0] d_instr;

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .f_addr     (f_addr),
        .mispred    (mispred),
        .ready      (ready),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .d_valid    (d_valid),
        .d_ready    (d_ready),
        .d_addr     (d_addr),
        .d_instr    (d_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] i;
    } ent_t;

    ent_t            q[$];
    bit              inflight;
    bit              dropped;
    logic [XLEN-1:0] infl_addr;

    int n_cmp;
    int n_bad;

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    initial begin
        logic [XLEN-1:0] pc;
        int              ack_in;
        bit              late_ack;
        bit              exp_acc;
        bit              exp_byp;
        bit              exp_dv;
        logic [XLEN-1:0] exp_da;
        logic [XLEN-1:0] exp_di;
        bit              do_rst;
        bit              pop;

        n_cmp    = 0;
        n_bad    = 0;
        pc       = '0;
        ack_in   = 0;
        late_ack = 1'b0;
        inflight = 1'b0;
        dropped  = 1'b0;
        infl_addr = '0;

        rst        = 1'b1;
        f_addr     = '0;
        mispred    = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        d_ready    = 1'b0;
        #1;
        check("rst_ready",   XLEN'(ready),    '0);
        check("rst_req",     XLEN'(imem_req), '0);
        check("rst_dvalid",  XLEN'(d_valid),  '0);
        check("rst_daddr",   d_addr,          '0);
        check("rst_dinstr",  d_instr,         '0);
        repeat (2) @(posedge clk);

        for (int cyc = 0; cyc < int'(NCYC); cyc++) begin
            @(negedge clk);
            rst = 1'b0;

            // Stimulus: alternate backpressure-heavy and drain-heavy phases.
            mispred    = ($urandom_range(0, 9) == 0);
            d_ready    = ((cyc % 200) < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            imem_ack   = (ack_in == 1) || late_ack;
            imem_rdata = $urandom;
            f_addr     = pc;
            late_ack   = 1'b0;

            // Expected outputs from the transaction model.
            exp_acc = !inflight && !mispred && (q.size() < int'(DEPTH));
`ifdef FETCH_QUEUE_BYPASS_EN
            exp_byp = inflight && !dropped && imem_ack && !mispred && (q.size() == 0) && d_ready;
`else
            exp_byp = 1'b0;
`endif
            exp_dv = (q.size() != 0) || exp_byp;
            if (q.size() != 0) begin
                exp_da = q[0].a;
                exp_di = q[0].i;
            end else if (exp_byp) begin
                exp_da = infl_addr;
                exp_di = imem_rdata;
            end else begin
                exp_da = '0;
                exp_di = '0;
            end

            #1;
            check("ready",   XLEN'(ready),    XLEN'(exp_acc || mispred));
            check("req",     XLEN'(imem_req), XLEN'(exp_acc));
            if (exp_acc) begin
                check("req_addr", imem_addr, f_addr);
            end
            check("d_valid", XLEN'(d_valid),  XLEN'(exp_dv));
            check("d_addr",  d_addr,          exp_da);
            check("d_instr", d_instr,         exp_di);

            do_rst = ($urandom_range(0, 149) == 0);
            if (do_rst) begin
                // Asynchronous reset between edges; outputs must clear at once.
                #1 rst = 1'b1;
                #1;
                check("arst_ready",  XLEN'(ready),    '0);
                check("arst_req",    XLEN'(imem_req), '0);
                check("arst_dvalid", XLEN'(d_valid),  '0);
                check("arst_daddr",  d_addr,          '0);
                check("arst_dinstr", d_instr,         '0);
                q.delete();
                inflight = 1'b0;
                dropped  = 1'b0;
                pc       = '0;
                ack_in   = 0;
                late_ack = 1'b1;
            end else begin
                // Model update for the coming edge.
                pop = (q.size() != 0) && d_ready;
                if (mispred) begin
                    q.delete();
                    if (inflight) begin
                        if (imem_ack) inflight = 1'b0;
                        else          dropped  = 1'b1;
                    end
                end else begin
                    if (pop) void'(q.pop_front());
                    if (inflight && imem_ack) begin
                        if (!dropped && !exp_byp) q.push_back('{a: infl_addr, i: imem_rdata});
                        inflight = 1'b0;
                    end
                    if (exp_acc) begin
                        inflight  = 1'b1;
                        dropped   = 1'b0;
                        infl_addr = f_addr;
                    end
                end
                if (exp_acc || mispred) begin
                    pc = mispred ? ($urandom & 32'hFFFF_FFFC) : pc + 32'd4;
                end
                if (ack_in > 0) ack_in--;
                if (exp_acc) ack_in = $urandom_range(1, 4);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
